// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone fetch/data memory arbiter.
package wb_arb_pkg;

  // State encoding matches the one-hot grant vector {data, fetch}
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_GNT_I = 2'b01,
    ARB_GNT_D = 2'b10
  } arb_state_e;

  localparam logic [1:0] GRANT_I = 2'b01;
  localparam logic [1:0] GRANT_D = 2'b10;

  // Width of the bus-hold watchdog counter
  localparam int TIMEOUT_W = 16;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus-hold watchdog: counts consecutive granted cycles without a slave
// response and flags expiry once the count reaches TIMEOUT_CYCLES.
// Only instantiated when WB_ARB_TIMEOUT_EN is defined.
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_active,
  input  logic i_clear,
  output logic o_expired
);

  localparam logic [TIMEOUT_W-1:0] LP_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

  logic [TIMEOUT_W-1:0] r_cnt;

  // Expiry is flagged in the granted cycle where the count hits the limit
  assign o_expired = i_active & (r_cnt == LP_LIMIT);

  // Count granted cycles; restart when idle, on a response, or on expiry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (!i_active || i_clear || o_expired) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master (fetch / data) round-robin arbiter onto one shared Wishbone B4
// slave. Request signals are muxed combinationally from the owner; slave
// responses pass straight back to the owner with no added latency.
// Optional bus-hold watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // fetch master (read-only)
  input  logic                  i_cyc_i,
  input  logic                  i_stb_i,
  input  logic [ADDR_WIDTH-1:0] i_adr_i,
  input  logic [XLEN/8-1:0]     i_sel_i,
  output logic                  i_ack_o,
  output logic                  i_err_o,
  output logic [XLEN-1:0]       i_dat_o,
  // data master
  input  logic                  d_cyc_i,
  input  logic                  d_stb_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_adr_i,
  input  logic [XLEN-1:0]       d_dat_i,
  input  logic [XLEN/8-1:0]     d_sel_i,
  output logic                  d_ack_o,
  output logic                  d_err_o,
  output logic [XLEN-1:0]       d_dat_o,
  // shared slave
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [XLEN-1:0]       s_dat_o,
  output logic [XLEN/8-1:0]     s_sel_o,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic [XLEN-1:0]       s_dat_i,
  // status
  output logic [1:0]            grant_o,
  output logic                  timeout_o
);

  arb_state_e r_state;
  arb_state_e w_next;
  logic       r_last_d;   // 1: data master owned the bus most recently

  logic w_req_i;
  logic w_req_d;
  logic w_gnt_i;
  logic w_gnt_d;
  logic w_done;
  logic w_timeout;
  logic w_err;
  logic w_ack;

  assign w_req_i = i_cyc_i & i_stb_i;
  assign w_req_d = d_cyc_i & d_stb_i;
  assign w_gnt_i = (r_state == ARB_GNT_I);
  assign w_gnt_d = (r_state == ARB_GNT_D);
  assign w_done  = s_ack_i | s_err_i;

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .i_active (w_gnt_i | w_gnt_d),
    .i_clear  (w_done),
    .o_expired(w_timeout)
  );
`else
  // Without the watchdog the limit has no effect; a grant is held until
  // the owner finishes or aborts.
  logic [TIMEOUT_W-1:0] w_unused_limit;
  assign w_unused_limit = TIMEOUT_W'(TIMEOUT_CYCLES);
  assign w_timeout      = 1'b0;
`endif

  assign timeout_o = w_timeout;
  assign grant_o   = w_gnt_d ? GRANT_D : (w_gnt_i ? GRANT_I : 2'b00);

  // Next-state: round-robin on ties, immediate hand-over on completion
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_req_d && (!w_req_i || !r_last_d)) begin
          w_next = ARB_GNT_D;
        end else if (w_req_i) begin
          w_next = ARB_GNT_I;
        end
      end
      ARB_GNT_I: begin
        if (w_timeout || !i_cyc_i) begin
          w_next = ARB_IDLE;
        end else if (w_done) begin
          if (w_req_d)      w_next = ARB_GNT_D;
          else if (w_req_i) w_next = ARB_GNT_I;
          else              w_next = ARB_IDLE;
        end
      end
      ARB_GNT_D: begin
        if (w_timeout || !d_cyc_i) begin
          w_next = ARB_IDLE;
        end else if (w_done) begin
          if (w_req_i)      w_next = ARB_GNT_I;
          else if (w_req_d) w_next = ARB_GNT_D;
          else              w_next = ARB_IDLE;
        end
      end
      default: w_next = ARB_IDLE;
    endcase
  end

  // Arbiter state and last-owner memory (last owner resets to fetch)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ARB_IDLE;
      r_last_d <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == ARB_GNT_D) begin
        r_last_d <= 1'b1;
      end else if (w_next == ARB_GNT_I) begin
        r_last_d <= 1'b0;
      end
    end
  end

  // Slave request mux; fetch never writes, idle drives all zeros
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (w_gnt_i) begin
      s_cyc_o = i_cyc_i & ~w_timeout;
      s_stb_o = i_stb_i & ~w_timeout;
      s_adr_o = i_adr_i;
      s_sel_o = i_sel_i;
    end else if (w_gnt_d) begin
      s_cyc_o = d_cyc_i & ~w_timeout;
      s_stb_o = d_stb_i & ~w_timeout;
      s_we_o  = d_we_i;
      s_adr_o = d_adr_i;
      s_dat_o = d_dat_i;
      s_sel_o = d_sel_i;
    end
  end

  // Error (slave or watchdog) takes precedence over ack
  assign w_err = s_err_i | w_timeout;
  assign w_ack = s_ack_i & ~w_err;

  // Responses reach only the owner, and only while its cycle is live
  always_comb begin
    i_ack_o = w_gnt_i & i_cyc_i & w_ack;
    i_err_o = w_gnt_i & i_cyc_i & w_err;
    i_dat_o = w_gnt_i ? s_dat_i : '0;
    d_ack_o = w_gnt_d & d_cyc_i & w_ack;
    d_err_o = w_gnt_d & d_cyc_i & w_err;
    d_dat_o = w_gnt_d ? s_dat_i : '0;
  end

endmodule
